// File: rtl/sseg_scan_mux.sv
// Four-digit 7-segment scanner: one digit per slot, each slot opened by a blanking gap.
// Latency: inputs sampled once per slot at the blank->show edge; outputs registered; free-running, no backpressure.
module sseg_scan_mux #(
  parameter int DIGIT_CYCLES   = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [7:0] sseg0_in,
  input  logic [7:0] sseg1_in,
  input  logic [7:0] sseg2_in,
  input  logic [7:0] sseg3_in,
  input  logic [3:0] digit_en,
  output logic [7:0] seg_out,
  output logic [3:0] an_out,
  output logic       frame_tick
);

  localparam int CW = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_CAPT = CW'(BLANK_CYCLES - 1);
  localparam logic [7:0]    SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [3:0]    AN_OFF   = (AN_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

  typedef enum logic {BLANK, SHOW} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          tick_q, tick_d;

  logic [7:0]    sel_pat;
  logic [3:0]    sel_onehot;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= BLANK;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      tick_q  <= tick_d;
    end
  end

  always_comb begin
    sel_pat = sseg0_in;
    case (idx_q)
      2'd0:    sel_pat = sseg0_in;
      2'd1:    sel_pat = sseg1_in;
      2'd2:    sel_pat = sseg2_in;
      default: sel_pat = sseg3_in;
    endcase
    sel_onehot = 4'b0001 << idx_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    seg_d   = seg_q;
    an_d    = an_q;
    tick_d  = 1'b0;

    // Slot timing runs independently of the enable mask so the scan rate never changes.
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end

    case (state_q)
      BLANK: begin
        if (cnt_q == CNT_CAPT) begin
          state_d = SHOW;
          // The output flops double as the holding registers: no mid-slot tearing.
          if (digit_en[idx_q]) begin
            seg_d = sel_pat ^ SEG_OFF;
            an_d  = sel_onehot ^ AN_OFF;
          end else begin
            seg_d = SEG_OFF;
            an_d  = AN_OFF;
          end
        end
      end
      SHOW: begin
        if (cnt_q == CNT_LAST) begin
          state_d = BLANK;
          seg_d   = SEG_OFF;
          an_d    = AN_OFF;
          tick_d  = (idx_q == 2'd3);
        end
      end
      default: begin
        state_d = BLANK;
        seg_d   = SEG_OFF;
        an_d    = AN_OFF;
      end
    endcase
  end

  assign seg_out    = seg_q;
  assign an_out     = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Bench for sseg_scan_mux: active-low and active-high instances fed identical stimulus,
// checked every cycle against a slot-arithmetic model plus literal spot checks.
module tb_sseg_scan_mux;

  logic       clk;
  logic       rst_n;
  logic [7:0] s0, s1, s2, s3;
  logic [3:0] en;
  logic [7:0] seg_a, seg_b;
  logic [3:0] an_a, an_b;
  logic       tick_a, tick_b;

  int checks = 0;
  int errors = 0;

  sseg_scan_mux #(.DIGIT_CYCLES(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut_a (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .sseg0_in(s0), .sseg1_in(s1), .sseg2_in(s2), .sseg3_in(s3), .digit_en(en),
    .seg_out(seg_a), .an_out(an_a), .frame_tick(tick_a)
  );

  sseg_scan_mux #(.DIGIT_CYCLES(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) dut_b (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .sseg0_in(s0), .sseg1_in(s1), .sseg2_in(s2), .sseg3_in(s3), .digit_en(en),
    .seg_out(seg_b), .an_out(an_b), .frame_tick(tick_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: n = clock edges since reset release; slot/phase follow from plain arithmetic.
  int         n;
  logic [7:0] m_pat;
  logic       m_en;

  function automatic logic [7:0] pick(input int i);
    case (i)
      0:       return s0;
      1:       return s1;
      2:       return s2;
      default: return s3;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n     = 0;
      m_pat = 8'h00;
      m_en  = 1'b0;
    end else begin
      n = n + 1;
      if (n % 8 == 2) begin
        m_pat = pick((n / 8) % 4);
        m_en  = en[(n / 8) % 4];
      end
    end
  end

  logic [3:0] e_an;
  logic [7:0] e_seg;
  logic       e_tick;

  always @(negedge clk) begin
    e_an  = 4'h0;
    e_seg = 8'h00;
    if (n > 0 && (n % 8) >= 2 && m_en) begin
      e_an[(n / 8) % 4] = 1'b1;
      e_seg = m_pat;
    end
    e_tick = (n > 0) && (n % 32 == 0);
    chk("model_an_lo",   {28'd0, an_a},   {28'd0, ~e_an});
    chk("model_seg_lo",  {24'd0, seg_a},  {24'd0, ~e_seg});
    chk("model_tick_lo", {31'd0, tick_a}, {31'd0, e_tick});
    chk("model_an_hi",   {28'd0, an_b},   {28'd0, e_an});
    chk("model_seg_hi",  {24'd0, seg_b},  {24'd0, e_seg});
    chk("model_tick_hi", {31'd0, tick_b}, {31'd0, e_tick});
  end

  task automatic go(input int target);
    int k;
    k = 0;
    while (n != target && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (n != target) begin
      checks++;
      errors++;
      $display("FAIL go_timeout: got n=%0d required n=%0d", n, target);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish required finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    s0 = 8'h06; s1 = 8'h5B; s2 = 8'h4F; s3 = 8'h66;
    en = 4'hF;
    repeat (3) @(negedge clk);

    // Reset values, both polarities
    chk("rst_seg_lo",  {24'd0, seg_a}, 32'hFF);
    chk("rst_an_lo",   {28'd0, an_a},  32'hF);
    chk("rst_tick_lo", {31'd0, tick_a}, 32'h0);
    chk("rst_seg_hi",  {24'd0, seg_b}, 32'h00);
    chk("rst_an_hi",   {28'd0, an_b},  32'h0);
    rst_n = 1'b1;

    // Scan order and blanking
    go(1);  chk("blank_n1_an",  {28'd0, an_a},  32'hF);
    go(2);  chk("d0_an",        {28'd0, an_a},  32'hE);
            chk("d0_seg",       {24'd0, seg_a}, 32'hF9);
            chk("d0_an_hi",     {28'd0, an_b},  32'h1);
            chk("d0_seg_hi",    {24'd0, seg_b}, 32'h06);
    go(7);  chk("d0_last_an",   {28'd0, an_a},  32'hE);
    go(8);  chk("gap_an",       {28'd0, an_a},  32'hF);
            chk("gap_seg",      {24'd0, seg_a}, 32'hFF);
    go(10); chk("d1_an",        {28'd0, an_a},  32'hD);
            chk("d1_seg",       {24'd0, seg_a}, 32'hA4);
    go(18); chk("d2_an",        {28'd0, an_a},  32'hB);
            chk("d2_seg",       {24'd0, seg_a}, 32'hB0);
    go(26); chk("d3_an",        {28'd0, an_a},  32'h7);
            chk("d3_seg",       {24'd0, seg_a}, 32'h99);
    go(31); chk("tick_pre",     {31'd0, tick_a}, 32'h0);
    go(32); chk("tick_first",   {31'd0, tick_a}, 32'h1);
    go(33); chk("tick_one_cyc", {31'd0, tick_a}, 32'h0);

    // No tearing: change digit 1 mid-show
    go(44); s1 = 8'h3F;
    go(45); chk("tear_hold",    {24'd0, seg_a}, 32'hA4);
    go(47); chk("tear_hold_end", {24'd0, seg_a}, 32'hA4);
    go(74); chk("tear_next_seg", {24'd0, seg_a}, 32'hC0);
            chk("tear_next_an",  {28'd0, an_a},  32'hD);

    // Disabled digit 2; digit 3 pattern for polarity check
    go(76); en = 4'b1011; s3 = 8'h80;
    for (int k = 80; k <= 87; k++) begin
      go(k);
      chk("dis_an",  {28'd0, an_a},  32'hF);
      chk("dis_seg", {24'd0, seg_a}, 32'hFF);
    end
    go(88); chk("pol_blank_an_hi",  {28'd0, an_b},  32'h0);
            chk("pol_blank_seg_hi", {24'd0, seg_b}, 32'h00);
    go(90); chk("d3_dp_an",     {28'd0, an_a},  32'h7);
            chk("d3_dp_seg",    {24'd0, seg_a}, 32'h7F);
            chk("pol_an_hi",    {28'd0, an_b},  32'h8);
            chk("pol_seg_hi",   {24'd0, seg_b}, 32'h80);
    go(96); chk("tick_period",  {31'd0, tick_a}, 32'h1);
    go(98); chk("d0_after_dis", {28'd0, an_a},  32'hE);

    // Async reset during digit 2 show
    go(100); en = 4'hF;
    go(115); chk("pre_rst_an",  {28'd0, an_a},  32'hB);
             chk("pre_rst_seg", {24'd0, seg_a}, 32'hB0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_seg_lo",  {24'd0, seg_a}, 32'hFF);
    chk("async_an_lo",   {28'd0, an_a},  32'hF);
    chk("async_seg_hi",  {24'd0, seg_b}, 32'h00);
    chk("async_an_hi",   {28'd0, an_b},  32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    go(2);  chk("restart_d0_an",  {28'd0, an_a},  32'hE);
            chk("restart_d0_seg", {24'd0, seg_a}, 32'hF9);
    go(10); chk("restart_d1_seg", {24'd0, seg_a}, 32'hC0);
    go(34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
